extra1_lp: RTL and testbench



---
 rtl/extra1_lp_pkg.sv | 8 +
 rtl/extra1_lp_mul16x16.sv | 14 +
 rtl/extra1_lp.sv | 37 +++
 tb/tb_extra1_lp.sv | 139 +++++++++++++
 4 files changed

// File: rtl/extra1_lp_pkg.sv
// extra1_lp_pkg: widths, latency and result type for the extra1_lp multiply-add pipeline
package extra1_lp_pkg;
  localparam int OP_W = 32;
  localparam int HALF_W = 16;
  localparam int RES_W = 36;
  localparam int LATENCY = 3;
  typedef logic [RES_W-1:0] res_t;
endpackage

// File: rtl/extra1_lp_mul16x16.sv
// mul16x16: registered unsigned 16x16->32 multiplier, one product per clock
module mul16x16
  import extra1_lp_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [HALF_W-1:0]     a,
  input  logic [HALF_W-1:0]     b,
  output logic [2*HALF_W-1:0]   p
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) p <= '0;
    else p <= a * b;
endmodule

// File: rtl/extra1_lp.sv
// extra1_lp: three-stage pipeline computing Q = (A_in*B_in + C_in) mod 2^36
module extra1_lp
  import extra1_lp_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] A_in,
  input  logic [OP_W-1:0] B_in,
  input  logic [OP_W-1:0] C_in,
  output res_t            Q
);
  logic [OP_W-1:0] a_q, b_q, c_q, c_d;
  logic [2*HALF_W-1:0] pp0, pp1, pp2, pp3;
  res_t sum;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      c_d <= '0;
      Q <= '0;
    end else begin
      a_q <= A_in;
      b_q <= B_in;
      c_q <= C_in;
      c_d <= c_q;
      Q <= sum;
    end
  mul16x16 u_pp0 (.clk(clk), .rst_n(rst_n), .a(a_q[HALF_W-1:0]),    .b(b_q[HALF_W-1:0]),    .p(pp0));
  mul16x16 u_pp1 (.clk(clk), .rst_n(rst_n), .a(a_q[HALF_W-1:0]),    .b(b_q[OP_W-1:HALF_W]), .p(pp1));
  mul16x16 u_pp2 (.clk(clk), .rst_n(rst_n), .a(a_q[OP_W-1:HALF_W]), .b(b_q[HALF_W-1:0]),    .p(pp2));
  mul16x16 u_pp3 (.clk(clk), .rst_n(rst_n), .a(a_q[OP_W-1:HALF_W]), .b(b_q[OP_W-1:HALF_W]), .p(pp3));
  // Shifts at RES_W width drop every bit that cannot reach the 36-bit result
  always_comb
    sum = res_t'(pp0) + (res_t'(pp1) << HALF_W) + (res_t'(pp2) << HALF_W)
        + (res_t'(pp3) << OP_W) + res_t'(c_d);
endmodule

// File: tb/tb_extra1_lp.sv
// tb_extra1_lp: scoreboard bench for the extra1_lp multiply-add pipeline
module tb_extra1_lp;
  import extra1_lp_pkg::*;
  logic clk = 0;
  logic rst_n = 0;
  logic [OP_W-1:0] a_in = 0, b_in = 0, c_in = 0;
  res_t q;
  res_t exp_q[$];
  res_t e;
  int n_checks = 0;
  int n_fail = 0;

  extra1_lp dut (.clk(clk), .rst_n(rst_n), .A_in(a_in), .B_in(b_in), .C_in(c_in), .Q(q));

  always #5 clk = ~clk;

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    logic [63:0] full;
    full = {32'b0, a} * {32'b0, b} + {32'b0, c};
    return full[35:0];
  endfunction

  task automatic test_reset();
    rst_n = 0;
    for (int i = 0; i < 5; i++) begin
      a_in = $urandom; b_in = $urandom; c_in = $urandom;
      @(posedge clk); #1;
      n_checks++;
      if (q !== '0) begin n_fail++; $display("FAIL reset_hold: Q=%h required 0", q); end
    end
    a_in = 0; b_in = 0; c_in = 0;
    @(negedge clk);
    rst_n = 1;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      exp_q.push_back(model(a_in, b_in, c_in));
      if (exp_q.size() == LATENCY) void'(exp_q.pop_front());
      n_checks++;
      if (q !== '0) begin n_fail++; $display("FAIL reset_release: Q=%h required 0", q); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ta[3] = '{2, 1, 2};
    logic [31:0] tb[3] = '{3, 1, 2};
    logic [31:0] tc[3] = '{4, 1, 3};
    res_t fixed[3] = '{36'd10, 36'd2, 36'd7};
    for (int i = 0; i < 3 + LATENCY; i++) begin
      a_in = i < 3 ? ta[i] : 0; b_in = i < 3 ? tb[i] : 0; c_in = i < 3 ? tc[i] : 0;
      @(posedge clk); #1;
      exp_q.push_back(model(a_in, b_in, c_in));
      if (exp_q.size() == LATENCY) begin
        e = exp_q.pop_front();
        n_checks++;
        if (q !== e) begin n_fail++; $display("FAIL back_to_back[%0d]: Q=%h required %h", i, q, e); end
      end
      if (i >= 2 && i < 5) begin
        n_checks++;
        if (q !== fixed[i-2]) begin n_fail++; $display("FAIL b2b_fixed[%0d]: Q=%h required %h", i-2, q, fixed[i-2]); end
      end
    end
  endtask

  task automatic test_cross_half();
    logic [31:0] ta[3] = '{32'h0001_0000, 32'hFFFF_FFFF, 32'h0010_0000};
    logic [31:0] tb[3] = '{32'h0000_FFFF, 32'hFFFF_FFFF, 32'h0010_0000};
    logic [31:0] tc[3] = '{32'h0, 32'hFFFF_FFFF, 32'd5};
    res_t fixed[3] = '{36'h0_FFFF_0000, 36'hF_0000_0000, 36'd5};
    for (int i = 0; i < 3 + LATENCY; i++) begin
      a_in = i < 3 ? ta[i] : 0; b_in = i < 3 ? tb[i] : 0; c_in = i < 3 ? tc[i] : 0;
      @(posedge clk); #1;
      exp_q.push_back(model(a_in, b_in, c_in));
      if (exp_q.size() == LATENCY) begin
        e = exp_q.pop_front();
        n_checks++;
        if (q !== e) begin n_fail++; $display("FAIL cross_half[%0d]: Q=%h required %h", i, q, e); end
      end
      if (i >= 2 && i < 5) begin
        n_checks++;
        if (q !== fixed[i-2]) begin n_fail++; $display("FAIL cross_fixed[%0d]: Q=%h required %h", i-2, q, fixed[i-2]); end
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) begin
      a_in = 32'h100 + i; b_in = 32'h200 + i; c_in = 32'h7;
      @(posedge clk); #1;
      exp_q.push_back(model(a_in, b_in, c_in));
      if (exp_q.size() == LATENCY) begin
        e = exp_q.pop_front();
        n_checks++;
        if (q !== e) begin n_fail++; $display("FAIL pre_reset[%0d]: Q=%h required %h", i, q, e); end
      end
    end
    n_checks++;
    if (q === '0) begin n_fail++; $display("FAIL pre_reset_nonzero: Q=%h required nonzero", q); end
    rst_n = 0;
    #1;
    n_checks++;
    if (q !== '0) begin n_fail++; $display("FAIL async_reset: Q=%h required 0", q); end
    exp_q.delete();
    a_in = 0; b_in = 0; c_in = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      exp_q.push_back(model(a_in, b_in, c_in));
      if (exp_q.size() == LATENCY) void'(exp_q.pop_front());
      n_checks++;
      if (q !== '0) begin n_fail++; $display("FAIL flushed[%0d]: Q=%h required 0", i, q); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000 + LATENCY; i++) begin
      a_in = i < 10000 ? $urandom : 0; b_in = i < 10000 ? $urandom : 0; c_in = i < 10000 ? $urandom : 0;
      @(posedge clk); #1;
      exp_q.push_back(model(a_in, b_in, c_in));
      if (exp_q.size() == LATENCY) begin
        e = exp_q.pop_front();
        n_checks++;
        if (q !== e) begin n_fail++; $display("FAIL random[%0d]: Q=%h required %h", i, q, e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_cross_half();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
